// File: rtl/board_draw_sequencer_pkg.sv
// Shared constants for the board draw path: copy-engine memory selects, screen geometry,
// the empty tile code and the sequencer state encoding.
package board_draw_sequencer_pkg;

    localparam logic [1:0] MEM_TITLE = 2'b00;
    localparam logic [1:0] MEM_GAME  = 2'b01;
    localparam logic [1:0] MEM_END   = 2'b10;
    localparam logic [1:0] MEM_TILE  = 2'b11;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int TILE_PX  = 16;

    localparam logic [3:0] EMPTY_CODE         = 4'd0;
    localparam logic [5:0] TRANSPARENT_COLOUR = 6'b001100;

    // Idle cycles after copy_finished so the copy engine can re-arm before the next go.
    localparam int GAP_CYCLES = 2;

    typedef enum logic [3:0] {
        S_IDLE,
        S_BG_ISSUE,
        S_BG_WAIT,
        S_FETCH,
        S_LATCH,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_NEXT,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/board_draw_sequencer_grid_cursor.sv
// Row-major board cursor: col advances on enable, wraps into the next row, and o_last
// flags the final cell of the board.
module grid_cursor #(
    parameter int COLS = 20,
    parameter int ROWS = 15,
    parameter int CW   = $clog2(COLS),
    parameter int RW   = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_clr,
    input  logic          i_en,
    output logic [CW-1:0] o_col,
    output logic [RW-1:0] o_row,
    output logic          o_last
);

    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic          w_col_end;
    logic          w_row_end;

    assign w_col_end = (r_col == CW'(COLS - 1));
    assign w_row_end = (r_row == RW'(ROWS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_en) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_col  = r_col;
    assign o_row  = r_row;
    assign o_last = w_col_end && w_row_end;

endmodule

// File: rtl/board_draw_sequencer.sv
// Walks the game board and issues one copy-engine tile draw per non-empty cell.
// Define BACKGROUND_FIRST_EN to prefix every pass with a full-screen MEM_GAME draw.
module board_draw_sequencer
    import board_draw_sequencer_pkg::*;
#(
    parameter int         COLS       = 20,
    parameter int         ROWS       = 15,
    parameter logic [8:0] ORIGIN_X   = 9'd0,
    parameter logic [7:0] ORIGIN_Y   = 8'd0,
    parameter logic [3:0] EMPTY_TILE = EMPTY_CODE,
    parameter int         RD_LATENCY = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    output logic [8:0] board_addr,
    input  logic [3:0] board_code,
    output logic       copy_go,
    output logic [8:0] copy_X,
    output logic [7:0] copy_Y,
    output logic [1:0] copy_mem_sel,
    output logic [3:0] copy_tile_sel,
    input  logic       copy_finished,
    output logic       busy,
    output logic       done
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    seq_state_t    r_state;
    logic [1:0]    r_cnt;
    logic [CW-1:0] w_col;
    logic [RW-1:0] w_row;
    logic          w_last;
    logic          w_clr;
    logic          w_adv;
`ifdef BACKGROUND_FIRST_EN
    logic          r_bg;
`endif

    assign w_clr = (r_state == S_IDLE) && start;
    assign w_adv = (r_state == S_NEXT);

    grid_cursor #(.COLS(COLS), .ROWS(ROWS), .CW(CW), .RW(RW)) u_cursor (
        .clk    (clk),
        .rst    (reset_n),
        .i_clr  (w_clr),
        .i_en   (w_adv),
        .o_col  (w_col),
        .o_row  (w_row),
        .o_last (w_last)
    );

    // Cursor only moves in NEXT, so the address is stable through FETCH and LATCH.
    assign board_addr = 9'(w_row) * 9'(COLS) + 9'(w_col);

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            copy_go       <= 1'b0;
            copy_X        <= '0;
            copy_Y        <= '0;
            copy_mem_sel  <= '0;
            copy_tile_sel <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
`ifdef BACKGROUND_FIRST_EN
            r_bg          <= 1'b0;
`endif
        end else begin
            copy_go <= 1'b0;
            done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        r_cnt <= '0;
`ifdef BACKGROUND_FIRST_EN
                        r_bg          <= 1'b1;
                        copy_go       <= 1'b1;
                        copy_X        <= '0;
                        copy_Y        <= '0;
                        copy_mem_sel  <= MEM_GAME;
                        copy_tile_sel <= EMPTY_TILE;
                        r_state       <= S_BG_ISSUE;
`else
                        r_state <= S_FETCH;
`endif
                    end
                end
`ifdef BACKGROUND_FIRST_EN
                S_BG_ISSUE: r_state <= S_BG_WAIT;
                S_BG_WAIT: begin
                    if (copy_finished) begin
                        r_cnt   <= '0;
                        r_state <= S_GAP;
                    end
                end
`endif
                S_FETCH: begin
                    if (r_cnt == 2'(RD_LATENCY - 1)) r_state <= S_LATCH;
                    else                             r_cnt   <= r_cnt + 2'd1;
                end
                S_LATCH: begin
                    copy_tile_sel <= board_code;
                    copy_X        <= ORIGIN_X + 9'({w_col, 4'b0000});
                    copy_Y        <= ORIGIN_Y + 8'({w_row, 4'b0000});
                    copy_mem_sel  <= MEM_TILE;
                    if (board_code == EMPTY_TILE) begin
                        r_state <= S_NEXT;
                    end else begin
                        copy_go <= 1'b1;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: r_state <= S_WAIT;
                S_WAIT: begin
                    if (copy_finished) begin
                        r_cnt   <= '0;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_cnt == 2'(GAP_CYCLES - 1)) begin
`ifdef BACKGROUND_FIRST_EN
                        if (r_bg) begin
                            r_bg    <= 1'b0;
                            r_cnt   <= '0;
                            r_state <= S_FETCH;
                        end else begin
                            r_state <= S_NEXT;
                        end
`else
                        r_state <= S_NEXT;
`endif
                    end else begin
                        r_cnt <= r_cnt + 2'd1;
                    end
                end
                S_NEXT: begin
                    if (w_last) begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt   <= '0;
                        r_state <= S_FETCH;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_board_draw_sequencer.sv
// Scoreboard bench for board_draw_sequencer with a behavioural copy engine and board RAM.
module tb_board_draw_sequencer;
    import board_draw_sequencer_pkg::*;

    localparam int COLS  = 20;
    localparam int ROWS  = 15;
    localparam int NCELL = COLS * ROWS;

    typedef struct packed {
        logic [8:0] x;
        logic [7:0] y;
        logic [1:0] mem;
        logic [3:0] tile;
    } draw_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [8:0] board_addr;
    logic [3:0] board_code;
    logic       copy_go;
    logic [8:0] copy_X;
    logic [7:0] copy_Y;
    logic [1:0] copy_mem_sel;
    logic [3:0] copy_tile_sel;
    logic       copy_finished;
    logic       busy;
    logic       done;

    logic [3:0] board [NCELL];
    draw_t      exp_q [$];
    draw_t      mon_e;
    int n_checks = 0, n_fail = 0;
    int cyc = 0, s_cyc = 0, done_cyc = 0;
    int go_cnt = 0, done_cnt = 0;
    int fin_delay = 260;
    logic       ce_busy;
    int         ce_cnt, rearm;
    logic [8:0] last_x;
    logic [7:0] last_y;

    always #5 clk = ~clk;

    board_draw_sequencer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk           (clk),
        .reset_n       (rst),
        .start         (start),
        .board_addr    (board_addr),
        .board_code    (board_code),
        .copy_go       (copy_go),
        .copy_X        (copy_X),
        .copy_Y        (copy_Y),
        .copy_mem_sel  (copy_mem_sel),
        .copy_tile_sel (copy_tile_sel),
        .copy_finished (copy_finished),
        .busy          (busy),
        .done          (done)
    );

    function automatic void chk(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) board_code <= (board_addr < 9'(NCELL)) ? board[board_addr] : 4'd0;

    // Copy engine: finished fin_delay cycles after go, then a short re-arm window.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ce_busy <= 1'b0; ce_cnt <= 0; rearm <= 0; copy_finished <= 1'b0;
        end else begin
            copy_finished <= 1'b0;
            if (rearm > 0) rearm <= rearm - 1;
            if (ce_busy) begin
                if (ce_cnt <= 1) begin
                    copy_finished <= 1'b1; ce_busy <= 1'b0; rearm <= 3;
                end else ce_cnt <= ce_cnt - 1;
            end else if (copy_go) begin
                ce_busy <= 1'b1; ce_cnt <= fin_delay;
            end
        end
    end

    // Monitor: pops the expected draw on every go.
    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (copy_finished) begin
                chk("hold_x", int'(copy_X), int'(last_x));
                chk("hold_y", int'(copy_Y), int'(last_y));
            end
            if (copy_go) begin
                go_cnt++;
                last_x = copy_X; last_y = copy_Y;
                chk("go_rearm", int'(ce_busy || rearm > 0), 0);
                if (exp_q.size() == 0) chk("go_unexpected", 1, 0);
                else begin
                    mon_e = exp_q.pop_front();
                    chk("go_x", int'(copy_X), int'(mon_e.x));
                    chk("go_y", int'(copy_Y), int'(mon_e.y));
                    chk("go_mem", int'(copy_mem_sel), int'(mon_e.mem));
                    if (mon_e.mem == MEM_TILE) chk("go_tile", int'(copy_tile_sel), int'(mon_e.tile));
                end
            end
        end
    end

    task automatic clear_board();
        for (int i = 0; i < NCELL; i++) board[i] = 4'd0;
    endtask

    task automatic push_expected();
        draw_t d;
`ifdef BACKGROUND_FIRST_EN
        d.x = 9'd0; d.y = 8'd0; d.mem = MEM_GAME; d.tile = 4'd0;
        exp_q.push_back(d);
`endif
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (board[r*COLS+c] != 4'd0) begin
                    d.x = 9'(c*16); d.y = 8'(r*16); d.mem = 2'b11; d.tile = board[r*COLS+c];
                    exp_q.push_back(d);
                end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1; s_cyc = cyc;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int budget, input string name);
        int n = 0;
        while (done_cnt == base && n < budget) begin @(posedge clk); n++; end
        chk({name, "_done"}, done_cnt - base, 1);
    endtask

    task automatic wait_go(input int g0, input int budget, input string name);
        int n = 0;
        while (go_cnt == g0 && n < budget) begin @(posedge clk); n++; end
        chk({name, "_go_seen"}, int'(go_cnt > g0), 1);
    endtask

    task automatic run_pass(input string name, input int budget);
        int base = done_cnt;
        int g0 = go_cnt;
        int nexp;
        push_expected();
        nexp = exp_q.size();
        pulse_start();
        wait_done(base, budget, name);
        @(negedge clk);
        chk({name, "_busy_after"}, int'(busy), 0);
        chk({name, "_go_count"}, go_cnt - g0, nexp);
        chk({name, "_queue_left"}, exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_go"}, int'(copy_go), 0);
        chk({name, "_x"}, int'(copy_X), 0);
        chk({name, "_y"}, int'(copy_Y), 0);
        chk({name, "_mem"}, int'(copy_mem_sel), 0);
        chk({name, "_tile"}, int'(copy_tile_sel), 0);
        chk({name, "_busy"}, int'(busy), 0);
        chk({name, "_done"}, int'(done), 0);
        chk({name, "_addr"}, int'(board_addr), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, g0;
        clear_board();
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        rst = 1'b0;

        // All cells empty: pure walk, 3 cycles per cell plus the done cycle.
        run_pass("empty", 3000);
`ifndef BACKGROUND_FIRST_EN
        chk("empty_len", done_cyc - s_cyc, 901);
`endif

        // Single tile at col 3, row 2.
        board[2*COLS+3] = 4'd5;
        run_pass("single", 3000);

        // Full board, shortened engine delay to keep the run compact.
        for (int i = 0; i < NCELL; i++) board[i] = 4'd1;
        fin_delay = 12;
        run_pass("full", 20000);
        fin_delay = 260;

        // Start re-pulsed while waiting on the engine is dropped.
        clear_board();
        board[1*COLS+7] = 4'hA;
        base = done_cnt; g0 = go_cnt;
        push_expected();
        pulse_start();
        wait_go(g0, 2000, "restart");
        repeat (20) @(posedge clk);
        #1 chk("restart_busy", int'(busy), 1);
        repeat (3) begin pulse_start(); repeat (10) @(posedge clk); end
        wait_done(base, 3000, "restart");
        repeat (100) @(posedge clk);
        chk("restart_one_done", done_cnt - base, 1);
        chk("restart_queue_left", exp_q.size(), 0);

        // Async reset while waiting on the engine.
        clear_board();
        board[3*COLS+4] = 4'd9;
        board[3*COLS+6] = 4'd3;
        g0 = go_cnt;
        push_expected();
        pulse_start();
        wait_go(g0, 2000, "abort");
        repeat (30) @(posedge clk);
        #3 rst = 1'b1;
        #1 check_all_zero("abort");
        exp_q.delete();
        @(posedge clk); #1 rst = 1'b0;
        run_pass("after_rst", 5000);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
